// File: rtl/matmul_pkg.sv
// Shared defaults, sequencer state encoding and error bit positions for the
// matmul BRAM sequencer slice.
`timescale 1ns/1ps
package matmul_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int LANES_DEF  = 32;
  localparam int AWIDTH_DEF = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam int ERR_HOST  = 0;
  localparam int ERR_EARLY = 1;

endpackage

// File: rtl/mm_bank.sv
// Row-wide single-port RAM with registered address/write inputs and a
// registered read output, giving two cycles from address to data.
`timescale 1ns/1ps
module mm_bank #(
  parameter int DW = 512,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      we_q   <= 1'b0;
    end else begin
      addr_q <= addr;
      we_q   <= we;
    end
  end

  // Storage and data path carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    wdata_q <= wdata;
    if (we_q) begin
      mem[addr_q] <= wdata_q;
    end
    rdata_q <= mem[addr_q];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/matmul_bram_sequencer.sv
// Owns the A/B/C row banks, arbitrates host vs. core access and sequences one
// multiply per start pulse, writing C rows from core row-valid strobes.
`timescale 1ns/1ps
module matmul_bram_sequencer
  import matmul_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int ROWS   = 32,
  parameter int C_BASE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_we_a,
  input  logic                    host_we_b,
  input  logic                    host_re_c,
  input  logic [AWIDTH-1:0]       host_addr,
  input  logic [LANES*DWIDTH-1:0] host_wdata,
  output logic [LANES*DWIDTH-1:0] host_rdata,
  output logic                    host_rvalid,
  input  logic                    start,
  input  logic                    err_clr,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err,
  output logic                    core_start,
  input  logic [AWIDTH-1:0]       core_a_addr,
  input  logic [AWIDTH-1:0]       core_b_addr,
  output logic [LANES*DWIDTH-1:0] core_a_data,
  output logic [LANES*DWIDTH-1:0] core_b_data,
  input  logic [LANES*DWIDTH-1:0] core_c_data,
  input  logic                    core_c_valid,
  input  logic                    core_done
);

  localparam int RW = LANES * DWIDTH;
  localparam int CW = AWIDTH + 1;
  localparam logic [AWIDTH-1:0] C_BASE_A = AWIDTH'(C_BASE);
  localparam logic [CW-1:0]     ROWS_C   = CW'(ROWS);
  localparam logic [CW-1:0]     ROWS_M1  = CW'(ROWS - 1);

  if (ROWS < 1 || ROWS > (1 << AWIDTH)) begin : g_rows_check
    $error("matmul_bram_sequencer: ROWS must lie in 1..2**AWIDTH");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   c_wr_ptr_q, c_wr_ptr_d;
  logic            c_commit_q, c_commit_d;
  logic            c_last_q, c_last_d;
  logic            rd_pend_q, rd_pend_d;
  logic            host_rvalid_q, host_rvalid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            core_start_q, core_start_d;
  logic [1:0]      err_q, err_d;

  logic              idle, accept_c, last_row;
  logic [AWIDTH-1:0] a_addr, b_addr, c_addr;
  logic              a_we, b_we;

  always_comb begin
    state_d       = state_q;
    c_wr_ptr_d    = c_wr_ptr_q;
    idle          = (state_q == IDLE);
    accept_c      = (state_q == RUN) && core_c_valid && (c_wr_ptr_q < ROWS_C);
    last_row      = accept_c && (c_wr_ptr_q == ROWS_M1);
    c_commit_d    = accept_c;
    c_last_d      = last_row;
    rd_pend_d     = idle && host_re_c;
    host_rvalid_d = rd_pend_q;

    // A clear only removes old errors; anything flagged this cycle survives.
    err_d = err_clr ? 2'b00 : err_q;
    if (!idle && (host_we_a || host_we_b || host_re_c)) begin
      err_d[ERR_HOST] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          c_wr_ptr_d = '0;
        end
      end
      RUN: begin
        if (accept_c) begin
          c_wr_ptr_d = c_wr_ptr_q + 1'b1;
        end
        if (c_commit_q && c_last_q) begin
          state_d = FINISH;
        end else if (core_done && (c_wr_ptr_q != ROWS_C) && !last_row) begin
          state_d          = IDLE;
          err_d[ERR_EARLY] = 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    core_start_d = (state_d == RUN);
    done_d       = (state_d == FINISH);

    a_addr = idle ? host_addr : core_a_addr;
    b_addr = idle ? host_addr : core_b_addr;
    c_addr = idle ? host_addr : C_BASE_A + c_wr_ptr_q[AWIDTH-1:0];
    a_we   = idle && host_we_a;
    b_we   = idle && host_we_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      c_wr_ptr_q    <= '0;
      c_commit_q    <= 1'b0;
      c_last_q      <= 1'b0;
      rd_pend_q     <= 1'b0;
      host_rvalid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      core_start_q  <= 1'b0;
      err_q         <= 2'b00;
    end else begin
      state_q       <= state_d;
      c_wr_ptr_q    <= c_wr_ptr_d;
      c_commit_q    <= c_commit_d;
      c_last_q      <= c_last_d;
      rd_pend_q     <= rd_pend_d;
      host_rvalid_q <= host_rvalid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      core_start_q  <= core_start_d;
      err_q         <= err_d;
    end
  end

  mm_bank #(.DW(RW), .AW(AWIDTH)) u_bank_a (
    .clk(clk), .reset(reset), .addr(a_addr), .we(a_we),
    .wdata(host_wdata), .rdata(core_a_data)
  );

  mm_bank #(.DW(RW), .AW(AWIDTH)) u_bank_b (
    .clk(clk), .reset(reset), .addr(b_addr), .we(b_we),
    .wdata(host_wdata), .rdata(core_b_data)
  );

  mm_bank #(.DW(RW), .AW(AWIDTH)) u_bank_c (
    .clk(clk), .reset(reset), .addr(c_addr), .we(accept_c),
    .wdata(core_c_data), .rdata(host_rdata)
  );

  assign host_rvalid = host_rvalid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign core_start  = core_start_q;
  assign err         = err_q;

endmodule

// File: tb/tb_matmul_bram_sequencer.sv
// Directed bench: a default-configured sequencer plus a ROWS=16, C_BASE=120
// instance sharing the same stimulus to exercise C address wrap-around.
`timescale 1ns/1ps
module tb_matmul_bram_sequencer;
  import matmul_pkg::*;

  localparam int DW = 16;
  localparam int LN = 32;
  localparam int AW = 7;
  localparam int RW = LN * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_we_a, host_we_b, host_re_c;
  logic [AW-1:0] host_addr;
  logic [RW-1:0] host_wdata;
  logic          start, err_clr;
  logic [AW-1:0] core_a_addr, core_b_addr;
  logic [RW-1:0] core_c_data;
  logic          core_c_valid, core_done;

  logic [RW-1:0] o0_host_rdata, o1_host_rdata;
  logic          o0_host_rvalid, o1_host_rvalid;
  logic          o0_busy, o1_busy, o0_done, o1_done;
  logic [1:0]    o0_err, o1_err;
  logic          o0_core_start, o1_core_start;
  logic [RW-1:0] o0_core_a_data, o1_core_a_data, o0_core_b_data, o1_core_b_data;

  int tests = 0;
  int fails = 0;
  logic [RW-1:0] row_x;

  always #5 clk = ~clk;

  matmul_bram_sequencer u0 (
    .clk(clk), .reset(reset),
    .host_we_a(host_we_a), .host_we_b(host_we_b), .host_re_c(host_re_c),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(o0_host_rdata), .host_rvalid(o0_host_rvalid),
    .start(start), .err_clr(err_clr),
    .busy(o0_busy), .done(o0_done), .err(o0_err), .core_start(o0_core_start),
    .core_a_addr(core_a_addr), .core_b_addr(core_b_addr),
    .core_a_data(o0_core_a_data), .core_b_data(o0_core_b_data),
    .core_c_data(core_c_data), .core_c_valid(core_c_valid), .core_done(core_done)
  );

  matmul_bram_sequencer #(.ROWS(16), .C_BASE(120)) u1 (
    .clk(clk), .reset(reset),
    .host_we_a(host_we_a), .host_we_b(host_we_b), .host_re_c(host_re_c),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(o1_host_rdata), .host_rvalid(o1_host_rvalid),
    .start(start), .err_clr(err_clr),
    .busy(o1_busy), .done(o1_done), .err(o1_err), .core_start(o1_core_start),
    .core_a_addr(core_a_addr), .core_b_addr(core_b_addr),
    .core_a_data(o1_core_a_data), .core_b_data(o1_core_b_data),
    .core_c_data(core_c_data), .core_c_valid(core_c_valid), .core_done(core_done)
  );

  function automatic logic [RW-1:0] mk_row(input logic [15:0] base);
    logic [RW-1:0] r;
    for (int k = 0; k < LN; k++) begin
      r[k*DW +: DW] = base + 16'(k);
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] c_row(input int i);
    return mk_row(16'(i) << 8);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int row_id);
    core_c_valid = 1'b1;
    core_c_data  = c_row(row_id);
    tick(1);
    core_c_valid = 1'b0;
  endtask

  task automatic send_rows(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(base + i);
    end
  endtask

  task automatic host_read(input string tag, input bit sel, input int addr, input logic [RW-1:0] exp);
    host_re_c = 1'b1;
    host_addr = AW'(addr);
    tick(1);
    host_re_c = 1'b0;
    checkOutput({tag, "_rvalid_early"}, sel ? o1_host_rvalid : o0_host_rvalid, 0);
    tick(1);
    checkOutput({tag, "_rvalid"}, sel ? o1_host_rvalid : o0_host_rvalid, 1);
    checkOutput({tag, "_rdata"}, sel ? o1_host_rdata : o0_host_rdata, exp);
  endtask

  initial begin
    reset = 1'b1;
    host_we_a = 1'b0; host_we_b = 1'b0; host_re_c = 1'b0;
    host_addr = '0; host_wdata = '0;
    start = 1'b0; err_clr = 1'b0;
    core_a_addr = '0; core_b_addr = '0;
    core_c_data = '0; core_c_valid = 1'b0; core_done = 1'b0;
    row_x = mk_row(16'h1000);

    tick(2);
    checkOutput("rst_busy", o0_busy, 0);
    checkOutput("rst_done", o0_done, 0);
    checkOutput("rst_core_start", o0_core_start, 0);
    checkOutput("rst_rvalid", o0_host_rvalid, 0);
    checkOutput("rst_err", o0_err, 0);
    reset = 1'b0;
    tick(1);

    // Same-cycle A and B host writes to row 3.
    host_addr = 7'd3; host_wdata = row_x; host_we_a = 1'b1; host_we_b = 1'b1;
    tick(1);
    host_we_a = 1'b0; host_we_b = 1'b0;
    tick(5);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("run_busy", o0_busy, 1);
    checkOutput("run_core_start", o0_core_start, 1);
    checkOutput("run_done", o0_done, 0);
    core_a_addr = 7'd3; core_b_addr = 7'd3;
    tick(2);
    checkOutput("core_a_lat2", o0_core_a_data, row_x);
    checkOutput("core_b_lat2", o0_core_b_data, row_x);
    checkOutput("u1_core_a_lat2", o1_core_a_data, row_x);
    checkOutput("u1_core_b_lat2", o1_core_b_data, row_x);
    checkOutput("u1_core_start", o1_core_start, 1);

    // Host write and a second start while busy: both must be ignored.
    send_rows(0, 10);
    host_we_a = 1'b1; host_addr = 7'd3; host_wdata = mk_row(16'h2000); start = 1'b1;
    tick(1);
    host_we_a = 1'b0; start = 1'b0;
    checkOutput("busy_host_err", o0_err, 2'b01);
    checkOutput("busy_still", o0_busy, 1);
    tick(2);
    checkOutput("a_unchanged", o0_core_a_data, row_x);
    send_rows(10, 22);

    checkOutput("done_not_yet", o0_done, 0);
    tick(1);
    checkOutput("done_pulse", o0_done, 1);
    checkOutput("finish_busy", o0_busy, 1);
    checkOutput("finish_core_start", o0_core_start, 0);
    tick(1);
    checkOutput("done_single", o0_done, 0);
    checkOutput("idle_busy", o0_busy, 0);

    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checkOutput("err_clear", o0_err, 0);
    host_read("rd_c31", 1'b0, 31, c_row(31));
    host_read("rd_c0", 1'b0, 0, c_row(0));
    host_read("rd_c17", 1'b0, 17, c_row(17));

    // Core gives up after 10 of 32 rows.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    send_rows(0, 10);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    checkOutput("early_err", o0_err, 2'b10);
    checkOutput("early_busy", o0_busy, 0);
    checkOutput("early_done", o0_done, 0);
    tick(1);
    checkOutput("early_done_later", o0_done, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checkOutput("early_err_clr", o0_err, 0);

    // Pointer must restart at 0 after the aborted run; then reset mid-run.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    send_rows(64, 5);
    reset = 1'b1;
    tick(1);
    checkOutput("midrst_busy", o0_busy, 0);
    checkOutput("midrst_core_start", o0_core_start, 0);
    checkOutput("midrst_done", o0_done, 0);
    reset = 1'b0;
    tick(1);
    checkOutput("midrst_done_after", o0_done, 0);
    host_read("rd_ptr_restart0", 1'b0, 0, c_row(64));
    host_read("rd_ptr_restart3", 1'b0, 3, c_row(67));

    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("restart_busy", o0_busy, 1);
    applyStimulus(150);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    checkOutput("restart_early_err", o0_err, 2'b10);
    host_read("rd_after_reset_run", 1'b0, 0, c_row(150));

    // Wrap-around on the ROWS=16, C_BASE=120 instance.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    send_rows(32, 16);
    checkOutput("wrap_done_not_yet", o1_done, 0);
    tick(1);
    checkOutput("wrap_done", o1_done, 1);
    tick(1);
    checkOutput("wrap_idle", o1_busy, 0);
    checkOutput("wrap_err", o1_err, 0);
    host_read("wrap_c120", 1'b1, 120, c_row(32));
    host_read("wrap_c127", 1'b1, 127, c_row(39));
    host_read("wrap_c0", 1'b1, 0, c_row(40));
    host_read("wrap_c7", 1'b1, 7, c_row(47));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
